// File: rtl/uart_rx_frame_ctrl.sv
// UART receive framer: hunts for a SYNC byte, collects LEN + payload + XOR checksum into a
// local buffer, and streams the payload out over valid/ready only once the checksum matches.
module uart_rx_frame_ctrl #(
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] frame_len,
    output logic       frame_ok,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_tmo,
    output logic       err_ovr,
    output logic       busy
);

    localparam int unsigned     IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned     GapW    = $clog2(TIMEOUT_CLKS);
    localparam logic [GapW-1:0] GapLast = GapW'(TIMEOUT_CLKS - 1);
    localparam logic [GapW-1:0] GapOne  = GapW'(1);
    localparam logic [7:0]      MaxLen  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        StHunt,
        StLen,
        StPayload,
        StChk,
        StDrain
    } state_e;

    state_e          state_q;
    logic [7:0]      len_q;
    logic [7:0]      chk_q;
    logic [7:0]      idx_q;
    logic [7:0]      rd_q;
    logic [7:0]      rd_nxt;
    logic [GapW-1:0] gap_q;
    logic            gap_hit;
    logic [7:0]      buf_q [MAX_LEN];

    assign rd_nxt  = rd_q + 8'd1;
    // Idle cycle that would be the TIMEOUT_CLKS-th since the last byte.
    assign gap_hit = (gap_q == GapLast);
    assign busy    = (state_q != StHunt);

    // Frame FSM with registered stream outputs and single-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StHunt;
            len_q     <= 8'h00;
            chk_q     <= 8'h00;
            idx_q     <= 8'h00;
            rd_q      <= 8'h00;
            gap_q     <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_len <= 8'h00;
            frame_ok  <= 1'b0;
            err_chk   <= 1'b0;
            err_len   <= 1'b0;
            err_tmo   <= 1'b0;
            err_ovr   <= 1'b0;
        end else begin
            frame_ok <= 1'b0;
            err_chk  <= 1'b0;
            err_len  <= 1'b0;
            err_tmo  <= 1'b0;
            err_ovr  <= 1'b0;
            unique case (state_q)
                StHunt: begin
                    if (rx_rdy && rx_data == SYNC_BYTE) begin
                        state_q <= StLen;
                        gap_q   <= '0;
                    end
                end
                StLen: begin
                    if (rx_rdy) begin
                        gap_q <= '0;
                        if (rx_data == 8'h00 || rx_data > MaxLen) begin
                            err_len <= 1'b1;
                            state_q <= StHunt;
                        end else begin
                            len_q   <= rx_data;
                            chk_q   <= rx_data;
                            idx_q   <= 8'h00;
                            state_q <= StPayload;
                        end
                    end else if (gap_hit) begin
                        err_tmo <= 1'b1;
                        state_q <= StHunt;
                    end else begin
                        gap_q <= gap_q + GapOne;
                    end
                end
                StPayload: begin
                    if (rx_rdy) begin
                        gap_q                  <= '0;
                        buf_q[idx_q[IdxW-1:0]] <= rx_data;
                        chk_q                  <= chk_q ^ rx_data;
                        if (idx_q == len_q - 8'd1) begin
                            state_q <= StChk;
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end else if (gap_hit) begin
                        err_tmo <= 1'b1;
                        state_q <= StHunt;
                    end else begin
                        gap_q <= gap_q + GapOne;
                    end
                end
                StChk: begin
                    if (rx_rdy) begin
                        gap_q <= '0;
                        if (rx_data == chk_q) begin
                            // Preload the first byte so out_valid rises with frame_ok.
                            frame_ok  <= 1'b1;
                            frame_len <= len_q;
                            out_valid <= 1'b1;
                            out_data  <= buf_q[0];
                            out_last  <= (len_q == 8'd1);
                            rd_q      <= 8'h00;
                            state_q   <= StDrain;
                        end else begin
                            err_chk <= 1'b1;
                            state_q <= StHunt;
                        end
                    end else if (gap_hit) begin
                        err_tmo <= 1'b1;
                        state_q <= StHunt;
                    end else begin
                        gap_q <= gap_q + GapOne;
                    end
                end
                StDrain: begin
                    // Buffer is busy draining; any incoming byte is lost.
                    if (rx_rdy) begin
                        err_ovr <= 1'b1;
                    end
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_data  <= 8'h00;
                            out_last  <= 1'b0;
                            state_q   <= StHunt;
                        end else begin
                            rd_q     <= rd_nxt;
                            out_data <= buf_q[rd_nxt[IdxW-1:0]];
                            out_last <= (rd_nxt == len_q - 8'd1);
                        end
                    end
                end
                default: state_q <= StHunt;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: cycle table for the basic frame cases, directed corner
// sequences, and randomized frames checked against a frame-level model.
module tb_uart_rx_frame_ctrl;

    localparam int unsigned MaxLen = 16;
    localparam int unsigned Tmo    = 32;
    localparam logic [7:0]  Sync   = 8'hA5;

    localparam int KGood = 0;
    localparam int KChk  = 1;
    localparam int KLen  = 2;
    localparam int KTmo  = 3;

    localparam logic [3:0] EvOk  = 4'd1;
    localparam logic [3:0] EvChk = 4'd2;
    localparam logic [3:0] EvLen = 4'd3;
    localparam logic [3:0] EvTmo = 4'd4;
    localparam logic [3:0] EvOvr = 4'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [7:0] frame_len;
    logic       frame_ok;
    logic       err_chk;
    logic       err_len;
    logic       err_tmo;
    logic       err_ovr;
    logic       busy;

    uart_rx_frame_ctrl #(
        .MAX_LEN     (MaxLen),
        .SYNC_BYTE   (Sync),
        .TIMEOUT_CLKS(Tmo)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_rdy   (rx_rdy),
        .rx_data  (rx_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .frame_len(frame_len),
        .frame_ok (frame_ok),
        .err_chk  (err_chk),
        .err_len  (err_len),
        .err_tmo  (err_tmo),
        .err_ovr  (err_ovr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [7:0]  din;
        logic        ordy;
        logic [23:0] exp;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] ev_sig;
    int          ev_n;
    logic [7:0]  got_d[$];
    logic        got_l[$];
    int          excl_viol = 0;
    int          stab_viol = 0;
    logic [7:0]  exp_flen;
    int          gap_mode = 0;

    function automatic vec_t mk(logic rdy, logic [7:0] din, logic ordy, logic v, logic [7:0] d,
                                logic l, logic ok, logic [3:0] e, logic bz, logic [7:0] fl);
        vec_t r;
        r.rdy  = rdy;
        r.din  = din;
        r.ordy = ordy;
        r.exp  = {v, d, l, ok, e, bz, fl};
        return r;
    endfunction

    function automatic logic [23:0] snap();
        return {out_valid, out_data, out_last, frame_ok, err_chk, err_len, err_tmo, err_ovr,
                busy, frame_len};
    endfunction

    function automatic int pick_gap();
        if (gap_mode == 0) return 0;
        if (gap_mode == 2) return int'(Tmo) - 1;
        if ($urandom % 10 == 0) return int'(Tmo) - 1;
        return int'($urandom % 4);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic ev_push(input logic [3:0] code);
        ev_sig = (ev_sig << 4) | {60'd0, code};
        ev_n++;
    endtask

    // One clock: drive inputs after a falling edge, log the handshake the coming rising edge
    // will perform, then log pulses and stall stability after it.
    task automatic cycle(input logic rdy, input logic [7:0] d, input logic ordy);
        logic       hold;
        logic [7:0] hd;
        logic       hl;
        int         np;
        rx_rdy    = rdy;
        rx_data   = d;
        out_ready = ordy;
        if (rst && out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
        hold = rst && out_valid && !out_ready;
        hd   = out_data;
        hl   = out_last;
        @(negedge clk);
        if (hold && rst && !(out_valid && out_data == hd && out_last == hl)) stab_viol++;
        np = int'(frame_ok) + int'(err_chk) + int'(err_len) + int'(err_tmo) + int'(err_ovr);
        if (np > 1) excl_viol++;
        if (frame_ok) ev_push(EvOk);
        if (err_chk)  ev_push(EvChk);
        if (err_len)  ev_push(EvLen);
        if (err_tmo)  ev_push(EvTmo);
        if (err_ovr)  ev_push(EvOvr);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = pick_gap();
        repeat (g) cycle(1'b0, 8'($urandom), 1'($urandom));
        cycle(1'b1, b, 1'($urandom));
    endtask

    task automatic clear_log();
        ev_sig = 64'd0;
        ev_n   = 0;
        got_d.delete();
        got_l.delete();
    endtask

    // Frame-level model: what the spec says each kind of frame must produce.
    task automatic run_item(input int kind, input int len, input int rmode, input int n_ovr,
                            input int n_sent, input string tag);
        logic [7:0]  pl[$];
        logic [7:0]  chk;
        logic [7:0]  b;
        logic [63:0] exp_sig;
        int          rem;
        int          k;
        int          ovl;
        int          nn;
        logic        ordy;
        logic        r;
        clear_log();
        exp_sig = 64'd0;
        nn = int'($urandom % 3);
        repeat (nn) begin
            repeat ($urandom % 50) cycle(1'b0, 8'h00, 1'b0);
            b = 8'($urandom);
            if (b == Sync) b = 8'h5A;
            cycle(1'b1, b, 1'b0);
        end
        send_byte(Sync);
        chk = 8'(len);
        send_byte(8'(len));
        if (kind == KLen) begin
            exp_sig = {60'd0, EvLen};
        end else begin
            for (int i = 0; i < len; i++) begin
                if (kind == KTmo && i >= n_sent) break;
                b = ($urandom % 8 == 0) ? Sync : 8'($urandom);
                pl.push_back(b);
                chk ^= b;
                send_byte(b);
            end
            if (kind == KTmo) begin
                repeat (Tmo) cycle(1'b0, 8'h00, 1'b0);
                exp_sig = {60'd0, EvTmo};
            end else if (kind == KChk) begin
                send_byte(chk ^ 8'(1 + $urandom % 255));
                exp_sig = {60'd0, EvChk};
            end else begin
                send_byte(chk);
                exp_sig  = {60'd0, EvOk};
                exp_flen = 8'(len);
                rem = len;
                ovl = n_ovr;
                k   = 0;
                while (rem > 0 && k < 2000) begin
                    if (rmode == 0)      ordy = 1'($urandom);
                    else if (rmode == 1) ordy = 1'b1;
                    else if (rmode == 2) ordy = (k % 2 == 0);
                    else                 ordy = (k >= 40);
                    r = (ovl > 0) && ((k % 2 == 1) || (rem == 1 && ordy));
                    if (r) begin
                        ovl--;
                        exp_sig = (exp_sig << 4) | {60'd0, EvOvr};
                    end
                    cycle(r, 8'($urandom), ordy);
                    if (ordy) rem--;
                    k++;
                end
            end
        end
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check({tag, ".events"}, ev_sig, exp_sig);
        check({tag, ".flen"}, 64'(frame_len), 64'(exp_flen));
        check({tag, ".idle"}, 64'({busy, out_valid}), 64'd0);
        if (kind == KGood) begin
            check({tag, ".nbytes"}, 64'(got_d.size()), 64'(len));
            for (int i = 0; i < len && i < got_d.size(); i++) begin
                check({tag, ".byte"}, 64'({got_l[i], got_d[i]}), 64'({(i == len - 1), pl[i]}));
            end
        end else begin
            check({tag, ".nbytes"}, 64'(got_d.size()), 64'd0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   kind;
        int   len;

        // Frame A5 03 11 22 33 / 03 drained with ready high.
        tbl.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h00));
        tbl.push_back(mk(1, 8'h03, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h00));
        tbl.push_back(mk(1, 8'h11, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h00));
        tbl.push_back(mk(1, 8'h22, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h00));
        tbl.push_back(mk(1, 8'h33, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h00));
        tbl.push_back(mk(1, 8'h03, 1, 1, 8'h11, 0, 1, 4'h0, 1, 8'h03));
        tbl.push_back(mk(0, 8'h00, 1, 1, 8'h22, 0, 0, 4'h0, 1, 8'h03));
        tbl.push_back(mk(0, 8'h00, 1, 1, 8'h33, 1, 0, 4'h0, 1, 8'h03));
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 4'h0, 0, 8'h03));
        // Same frame with a bad checksum.
        tbl.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h03));
        tbl.push_back(mk(1, 8'h03, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h03));
        tbl.push_back(mk(1, 8'h11, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h03));
        tbl.push_back(mk(1, 8'h22, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h03));
        tbl.push_back(mk(1, 8'h33, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h03));
        tbl.push_back(mk(1, 8'h04, 1, 0, 8'h00, 0, 0, 4'h8, 0, 8'h03));
        tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 4'h0, 0, 8'h03));
        // LEN of 0 and of MAX_LEN+1, then a non-SYNC byte in HUNT.
        tbl.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h03));
        tbl.push_back(mk(1, 8'h00, 1, 0, 8'h00, 0, 0, 4'h4, 0, 8'h03));
        tbl.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h03));
        tbl.push_back(mk(1, 8'h11, 1, 0, 8'h00, 0, 0, 4'h4, 0, 8'h03));
        tbl.push_back(mk(1, 8'hFF, 0, 0, 8'h00, 0, 0, 4'h0, 0, 8'h03));
        // LEN=1 frame whose payload is the SYNC value, stalled, overrun on the last handshake.
        tbl.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h03));
        tbl.push_back(mk(1, 8'h01, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h03));
        tbl.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 4'h0, 1, 8'h03));
        tbl.push_back(mk(1, 8'hA4, 0, 1, 8'hA5, 1, 1, 4'h0, 1, 8'h01));
        tbl.push_back(mk(0, 8'h00, 0, 1, 8'hA5, 1, 0, 4'h0, 1, 8'h01));
        tbl.push_back(mk(1, 8'hA5, 1, 0, 8'h00, 0, 0, 4'h1, 0, 8'h01));
        tbl.push_back(mk(1, 8'h01, 1, 0, 8'h00, 0, 0, 4'h0, 0, 8'h01));

        rst       = 1'b0;
        rx_rdy    = 1'b0;
        rx_data   = 8'h00;
        out_ready = 1'b0;
        clear_log();
        @(negedge clk);
        repeat (3) cycle(1'b0, 8'h00, 1'b0);
        check("reset", 64'(snap()), 64'd0);
        rst = 1'b1;
        exp_flen = 8'h00;

        foreach (tbl[i]) begin
            cycle(tbl[i].rdy, tbl[i].din, tbl[i].ordy);
            check($sformatf("vec%0d", i), 64'(snap()), 64'(tbl[i].exp));
        end
        exp_flen = 8'h01;

        run_item(KGood, int'(MaxLen), 1, 0, 0, "len_max");

        // Timeout boundary: T-1 idle cycles are tolerated, the T-th drops the frame once.
        clear_log();
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);
        cycle(1'b1, Sync, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        cycle(1'b1, 8'h11, 1'b0);
        repeat (Tmo - 1) cycle(1'b0, 8'h00, 1'b0);
        check("tmo.before", 64'({busy, 4'(ev_n)}), 64'({1'b1, 4'd0}));
        cycle(1'b0, 8'h00, 1'b0);
        check("tmo.hit", ev_sig, {60'd0, EvTmo});
        check("tmo.busy", 64'(busy), 64'd0);
        repeat (40) cycle(1'b0, 8'h00, 1'b0);
        check("tmo.once", 64'(ev_n), 64'd1);

        gap_mode = 2;
        run_item(KGood, 2, 1, 0, 0, "gap_max");
        gap_mode = 0;
        run_item(KGood, 3, 2, 2, 0, "toggle_ovr");
        run_item(KGood, 2, 3, 1, 0, "long_stall");

        // Reset while collecting payload.
        clear_log();
        cycle(1'b1, Sync, 1'b0);
        cycle(1'b1, 8'h05, 1'b0);
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b1);
        check("rst_pay", 64'(snap()), 64'd0);
        rst = 1'b1;
        exp_flen = 8'h00;
        run_item(KGood, 4, 1, 0, 0, "after_rst_pay");

        // Reset while draining a stalled frame.
        clear_log();
        cycle(1'b1, Sync, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h31, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("pre_rst_drain", 64'({out_valid, out_data}), 64'({1'b1, 8'h11}));
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b1);
        check("rst_drain", 64'(snap()), 64'd0);
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b1);
        check("rst_drain.events", ev_sig, {60'd0, EvOk});
        exp_flen = 8'h00;
        run_item(KGood, 5, 0, 1, 0, "after_rst_drain");

        gap_mode = 1;
        for (int it = 0; it < 60; it++) begin
            kind = int'($urandom % 6);
            len  = 1 + int'($urandom % MaxLen);
            if (kind <= 2) begin
                run_item(KGood, len, 0, int'($urandom % 3), 0, $sformatf("rnd%0d.good", it));
            end else if (kind == 3) begin
                run_item(KChk, len, 0, 0, 0, $sformatf("rnd%0d.chk", it));
            end else if (kind == 4) begin
                len = ($urandom % 2 == 0) ? 0 : int'(MaxLen) + 1 + int'($urandom % (255 - MaxLen));
                run_item(KLen, len, 0, 0, 0, $sformatf("rnd%0d.len", it));
            end else begin
                run_item(KTmo, len, 0, 0, int'($urandom % (len + 1)), $sformatf("rnd%0d.tmo", it));
            end
        end

        check("excl", 64'(excl_viol), 64'd0);
        check("stable", 64'(stab_viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
